data_memory_bytelane: RTL and testbench



---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_memory_bytelane.sv | 117 +++++++++++
 tb/tb_data_memory_bytelane.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the byte-lane data memory.
package mem_pkg;

  // Access size field carried on the size port.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  // Handshake FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for
// writes, lane extraction plus sign/zero extension for loads.
// misalign also covers the illegal size encoding, so it means "fault".
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  ofs,
  input  logic        zext,
  input  logic [31:0] idata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  // Decode size/offset into enables, store word and extended load value.
  always_comb begin
    be       = '0;
    wword    = '0;
    ldata    = '0;
    misalign = 1'b0;
    b        = rword[{ofs, 3'b000} +: 8];
    h        = ofs[1] ? rword[31:16] : rword[15:0];
    case (size_t'(size))
      SZ_BYTE: begin
        be    = 4'b0001 << ofs;
        wword = {4{idata[7:0]}};
        ldata = {{24{~zext & b[7]}}, b};
      end
      SZ_HALF: begin
        misalign = ofs[0];
        wword    = {2{idata[15:0]}};
        if (!ofs[0]) begin
          be    = ofs[1] ? 4'b1100 : 4'b0011;
          ldata = {{16{~zext & h[15]}}, h};
        end
      end
      SZ_WORD: begin
        misalign = |ofs;
        wword    = idata;
        if (ofs == 2'b00) begin
          be    = '1;
          ldata = rword;
        end
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Word-organised data memory with byte lanes and a req/ready, valid/ack
// handshake; the response is registered one cycle after acceptance.
module data_memory_bytelane
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2     = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  output logic        ready,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] addr,
  input  logic [31:0] idata,
  output logic        valid,
  input  logic        ack,
  output logic [31:0] odata,
  output logic        fault
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  state_t                  state_q, state_d;
  logic [31:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             rword;
  logic [3:0]              be;
  logic [3:0]              we;
  logic [31:0]             wword;
  logic [31:0]             ldata;
  logic                    misalign;
  logic                    accept;
  logic [31:0]             odata_q;
  logic                    fault_q;

  assign idx    = addr[DEPTH_LOG2+1:2];
  assign rword  = mem[idx];
  assign accept = req && (state_q == ST_IDLE);
  assign we     = (accept && write && !misalign) ? be : '0;

  mem_lane_align u_align (
    .size     (size),
    .ofs      (addr[1:0]),
    .zext     (zext),
    .idata    (idata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .ldata    (ldata),
    .misalign (misalign)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) state_d = ST_RESP;
      end
      ST_RESP: begin
        valid = 1'b1;
        if (ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers, loaded only on acceptance and held through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odata_q <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= misalign;
      odata_q <= (write || misalign) ? '0 : ldata;
    end
  end

  assign odata = odata_q;
  assign fault = fault_q;

  generate
    if (CLEAR_ON_RESET) begin : g_clear
      // Storage with per-lane write enables, cleared by reset.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
          for (int unsigned l = 0; l < 4; l++)
            if (we[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
        end
      end
    end else begin : g_keep
      // Storage with per-lane write enables; contents survive reset but a
      // store coinciding with reset is still dropped.
      always_ff @(posedge clock) begin
        if (!reset) begin
          for (int unsigned l = 0; l < 4; l++)
            if (we[l]) mem[idx][8*l +: 8] <= wword[8*l +: 8];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Randomised and directed bench with a byte-addressed reference model.
module tb_data_memory_bytelane;

  localparam int NB = 32;  // bytes of storage for DEPTH_LOG2=3

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req   = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  size  = 2'b00;
  logic        zext  = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] idata = '0;
  logic        ack   = 1'b0;
  logic        ready, valid, fault;
  logic [31:0] odata;

  int checks = 0;
  int errors = 0;

  data_memory_bytelane #(.DEPTH_LOG2(3), .CLEAR_ON_RESET(1'b1)) dut (
    .clock (clock), .reset (reset), .req (req), .ready (ready),
    .write (write), .size (size), .zext (zext), .addr (addr),
    .idata (idata), .valid (valid), .ack (ack), .odata (odata),
    .fault (fault)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [7:0]  mb [NB];
  logic        m_busy  = 1'b0;
  logic [31:0] m_odata = '0;
  logic        m_fault = 1'b0;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
    if (s == 2'b11) return 1'b1;
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [1:0] s,
                                           input logic [31:0] a,
                                           input logic z);
    int n = nbytes(s);
    int base = int'(a % NB);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[(base + i) % NB]) << (8 * i));
    if (n < 4 && !z && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_odata <= '0;
      m_fault <= 1'b0;
      for (int i = 0; i < NB; i++) mb[i] <= '0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy  <= 1'b1;
        m_fault <= is_bad(size, addr);
        m_odata <= (write || is_bad(size, addr)) ? '0 : load_val(size, addr, zext);
        if (write && !is_bad(size, addr))
          for (int i = 0; i < nbytes(size); i++)
            mb[(int'(addr % NB) + i) % NB] <= idata[8*i +: 8];
      end
    end else if (ack) begin
      m_busy <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    chk("ready", 32'(ready), 32'(!m_busy));
    chk("valid", 32'(valid), 32'(m_busy));
    if (m_busy || reset) begin
      chk("odata", odata, m_odata);
      chk("fault", 32'(fault), 32'(m_fault));
    end
  end

  // One full transaction; called at posedge+1 with the DUT idle.
  task automatic acc(input logic w, input logic [1:0] sz, input logic z,
                     input logic [31:0] a, input logic [31:0] d, input int hold,
                     input bit dir, input logic [31:0] eo, input logic ef,
                     input string name);
    write = w; size = sz; zext = z; addr = a; idata = d; req = 1'b1;
    if (!dir) ack = 1'($urandom_range(0, 1));
    @(posedge clock); #1;
    req = 1'b0; ack = 1'b0;
    chk({name, " latency"}, 32'(valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      req  = 1'($urandom_range(0, 1));
      addr = $urandom;
      write = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      if (dir) begin
        chk({name, " hold valid"}, 32'(valid), 32'd1);
        chk({name, " hold ready"}, 32'(ready), 32'd0);
        chk({name, " hold odata"}, odata, eo);
      end
    end
    req = 1'b0;
    if (dir) begin
      chk({name, " odata"}, odata, eo);
      chk({name, " fault"}, 32'(fault), 32'(ef));
      chk({name, " model odata"}, m_odata, eo);
      chk({name, " model fault"}, 32'(m_fault), 32'(ef));
    end
    ack = 1'b1;
    @(posedge clock); #1;
    ack = 1'b0;
    chk({name, " idle after ack"}, 32'(ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("ready after reset", 32'(ready), 32'd1);

    // reset state and basic word access
    acc(0, 2'b10, 0, 32'h0,  32'h0,         0, 1, 32'h0000_0000, 0, "load0");
    acc(1, 2'b10, 0, 32'h8,  32'hDEAD_BEEF, 0, 1, 32'h0000_0000, 0, "stw8");
    acc(0, 2'b10, 0, 32'h8,  32'h0,         0, 1, 32'hDEAD_BEEF, 0, "ldw8");
    acc(0, 2'b10, 0, 32'h28, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, "alias28");

    // byte lanes and extension
    acc(1, 2'b10, 0, 32'h8, 32'h1122_3344, 0, 1, 32'h0,          0, "stw8b");
    acc(1, 2'b00, 0, 32'h9, 32'hFFFF_FF80, 0, 1, 32'h0,          0, "stb9");
    acc(0, 2'b10, 0, 32'h8, 32'h0,         0, 1, 32'h1122_8044,  0, "ldw8b");
    acc(0, 2'b00, 0, 32'h9, 32'h0,         0, 1, 32'hFFFF_FF80,  0, "ldb9s");
    acc(0, 2'b00, 1, 32'h9, 32'h0,         0, 1, 32'h0000_0080,  0, "ldb9z");
    acc(0, 2'b01, 0, 32'hA, 32'h0,         0, 1, 32'h0000_1122,  0, "ldhA");
    acc(1, 2'b01, 0, 32'hE, 32'h0000_A5C3, 0, 1, 32'h0,          0, "sthE");
    acc(0, 2'b01, 0, 32'hE, 32'h0,         0, 1, 32'hFFFF_A5C3,  0, "ldhEs");

    // faults
    acc(1, 2'b10, 0, 32'h6, 32'hFFFF_FFFF, 0, 1, 32'h0, 1, "stw6 fault");
    acc(0, 2'b10, 0, 32'h4, 32'h0,         0, 1, 32'h0, 0, "ldw4 unchanged");
    acc(0, 2'b01, 0, 32'h3, 32'h0,         0, 1, 32'h0, 1, "ldh3 fault");
    acc(1, 2'b11, 0, 32'h0, 32'h1234_5678, 0, 1, 32'h0, 1, "size11 fault");
    acc(0, 2'b10, 0, 32'h0, 32'h0,         0, 1, 32'h0, 0, "ldw0 unchanged");

    // handshake hold
    acc(0, 2'b10, 0, 32'h8, 32'h0, 5, 1, 32'h1122_8044, 0, "hold");

    // randomised traffic
    for (int k = 0; k < 300; k++) begin
      logic [1:0]  s  = 2'($urandom_range(0, 3));
      logic [31:0] a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(s) - 1);
      acc(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 2), 0, 32'h0, 0, "rand");
    end

    // reset during a response
    acc(1, 2'b10, 0, 32'h10, 32'hCAFE_F00D, 0, 1, 32'h0, 0, "stw10");
    write = 1'b0; size = 2'b10; zext = 1'b0; addr = 32'h10; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    chk("pre-reset odata", odata, 32'hCAFE_F00D);
    reset = 1'b1;
    #1;
    chk("async reset valid", 32'(valid), 32'd0);
    chk("async reset odata", odata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    acc(0, 2'b10, 0, 32'h10, 32'h0, 0, 1, 32'h0, 0, "cleared10");
    acc(0, 2'b10, 0, 32'h8,  32'h0, 0, 1, 32'h0, 0, "cleared8");

    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
